// File: rtl/pulse_train_ctrl_pkg.sv
// Shared types and default widths for the pulse-train sequencer.
// Optional abort path is enabled with PULSE_CTRL_ABORT_EN.
package pulse_ctrl_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/pulse_train_ctrl_if.sv
// Host-side bundle of the pulse-train sequencer.
// abort/aborted exist only when PULSE_CTRL_ABORT_EN is defined.
import pulse_ctrl_pkg::*;

interface pulse_train_ctrl_if #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
);
    logic             start;
    logic [WIDTH-1:0] period;
    logic [CNT_W-1:0] num_pulses;
    logic             pulse;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] pulses_left;
`ifdef PULSE_CTRL_ABORT_EN
    logic             abort;
    logic             aborted;

    modport master (output start, period, num_pulses, abort,
                    input  pulse, busy, done, pulses_left, aborted);
    modport slave  (input  start, period, num_pulses, abort,
                    output pulse, busy, done, pulses_left, aborted);
`else
    modport master (output start, period, num_pulses,
                    input  pulse, busy, done, pulses_left);
    modport slave  (input  start, period, num_pulses,
                    output pulse, busy, done, pulses_left);
`endif
endinterface

// File: rtl/pulse_period_counter.sv
// Period counter: counts 0..match_val and wraps, flagging the match cycle.
// Shared by builds with and without PULSE_CTRL_ABORT_EN.
module pulse_period_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] match_val,
    output logic             match
);
    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= (count < match_val) ? count + 1'b1 : '0;
        end
    end

    assign match = (count == match_val);

endmodule

// File: rtl/pulse_train_ctrl.sv
// Burst sequencer: N pulses spaced period+1 cycles apart, then a done strobe.
// Define PULSE_CTRL_ABORT_EN to add the abort/aborted path.
module pulse_train_ctrl
    import pulse_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic           clk,
    input  logic           rst,
    pulse_train_ctrl_if.slave bus
);
    state_t           state;
    logic [WIDTH-1:0] period_q;
    logic [CNT_W-1:0] left_q;
    logic             busy_q;
    logic             done_q;
    logic             match;
    logic             cnt_clr;
    logic             cnt_en;
    logic             pulse_w;
    logic             abort_req;
`ifdef PULSE_CTRL_ABORT_EN
    logic             aborted_q;
    assign abort_req   = bus.abort;
    assign bus.aborted = aborted_q;
`else
    assign abort_req   = 1'b0;
`endif

    assign cnt_clr = (state == IDLE) && bus.start;
    assign cnt_en  = (state == RUN);

    pulse_period_counter #(.WIDTH(WIDTH)) u_period_cnt (
        .clk       (clk),
        .rst       (rst),
        .clr       (cnt_clr),
        .en        (cnt_en),
        .match_val (period_q),
        .match     (match)
    );

    // Pulse is a pure decode of registered state so it lines up with the count.
    assign pulse_w = (state == RUN) && match;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            period_q <= '0;
            left_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef PULSE_CTRL_ABORT_EN
            aborted_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        period_q <= bus.period;
                        left_q   <= bus.num_pulses;
                        if (bus.num_pulses != '0) begin
                            state  <= RUN;
                            busy_q <= 1'b1;
                        end else begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    // Abort wins over the last-pulse exit; undelivered count is kept.
                    if (abort_req) begin
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
`ifdef PULSE_CTRL_ABORT_EN
                        aborted_q <= 1'b1;
`endif
                    end else if (pulse_w) begin
                        left_q <= left_q - 1'b1;
                        if (left_q == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                            state  <= DONE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    done_q <= 1'b0;
`ifdef PULSE_CTRL_ABORT_EN
                    aborted_q <= 1'b0;
`endif
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pulse       = pulse_w;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.pulses_left = left_q;

endmodule

// File: tb/tb_pulse_train_ctrl.sv
// Scoreboard bench for pulse_train_ctrl; abort scenario runs when PULSE_CTRL_ABORT_EN is defined.
module tb_pulse_train_ctrl;

    localparam int WIDTH = 4;
    localparam int CNT_W = 8;

    typedef struct {
        int cyc;
        int left;
        int ab;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   n_tests;
    int   n_fail;
    bit   mon_en;
    int   busy_lo;
    int   busy_hi;
    exp_t pq[$];
    exp_t dq[$];

    pulse_train_ctrl_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    pulse_train_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Monitor: compares DUT activity against queued expectations.
    always @(negedge clk) begin
        if (mon_en) begin
            exp_t e;
            check("busy", int'(bus.busy), int'(cyc >= busy_lo && cyc <= busy_hi));
            if (bus.pulse) begin
                if (pq.size() == 0) begin
                    check("pulse_unexpected_cycle", cyc, -1);
                end else begin
                    e = pq.pop_front();
                    check("pulse_cycle", cyc, e.cyc);
                    check("pulse_left", int'(bus.pulses_left), e.left);
                end
            end
            if (bus.done) begin
                if (dq.size() == 0) begin
                    check("done_unexpected_cycle", cyc, -1);
                end else begin
                    e = dq.pop_front();
                    check("done_cycle", cyc, e.cyc);
                    check("done_left", int'(bus.pulses_left), e.left);
`ifdef PULSE_CTRL_ABORT_EN
                    check("done_aborted", int'(bus.aborted), e.ab);
`endif
                end
            end
`ifdef PULSE_CTRL_ABORT_EN
            if (!bus.done) check("aborted_without_done", int'(bus.aborted), 0);
`endif
        end
    end

    task automatic drain_check();
        #1;
        check("pulse_queue_empty", pq.size(), 0);
        check("done_queue_empty", dq.size(), 0);
        pq.delete();
        dq.delete();
    endtask

    // Reference: pulse k of a burst accepted at the edge after cycle s
    // lands at s + k*(P+1); done at s + 1 + N*(P+1).
    task automatic run_burst(input int p, input int n, input bit hold);
        int s;
        int d;
        @(negedge clk);
        bus.period     = WIDTH'(p);
        bus.num_pulses = CNT_W'(n);
        bus.start      = 1'b1;
        s = cyc;
        d = s + 1 + n * (p + 1);
        for (int k = 1; k <= n; k++) pq.push_back('{s + k * (p + 1), n - k + 1, 0});
        dq.push_back('{d, 0, 0});
        busy_lo = s + 1;
        busy_hi = d - 1;
        if (!hold) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        while (cyc < d) begin
            @(negedge clk);
            if (hold && cyc < d) begin
                bus.period     = WIDTH'($urandom);
                bus.num_pulses = CNT_W'($urandom);
            end
        end
        bus.start = 1'b0;
        drain_check();
    endtask

    task automatic reset_mid_burst();
        int s;
        @(negedge clk);
        bus.period     = WIDTH'(15);
        bus.num_pulses = CNT_W'(2);
        bus.start      = 1'b1;
        s = cyc;
        busy_lo = s + 1;
        busy_hi = s + 10;
        @(negedge clk);
        bus.start = 1'b0;
        while (cyc < s + 10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_pulse", int'(bus.pulse), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_left", int'(bus.pulses_left), 0);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        drain_check();
    endtask

`ifdef PULSE_CTRL_ABORT_EN
    task automatic abort_burst();
        int s;
        @(negedge clk);
        bus.period     = WIDTH'(2);
        bus.num_pulses = CNT_W'(5);
        bus.start      = 1'b1;
        s = cyc;
        pq.push_back('{s + 3, 5, 0});
        pq.push_back('{s + 6, 4, 0});
        dq.push_back('{s + 8, 3, 1});
        busy_lo = s + 1;
        busy_hi = s + 7;
        @(negedge clk);
        bus.start = 1'b0;
        while (cyc < s + 7) @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        repeat (10) @(negedge clk);
        drain_check();
    endtask
`endif

    initial begin
        n_tests = 0;
        n_fail  = 0;
        mon_en  = 1'b0;
        busy_lo = 1;
        busy_hi = 0;
        rst     = 1'b1;
        bus.start      = 1'b0;
        bus.period     = '0;
        bus.num_pulses = '0;
`ifdef PULSE_CTRL_ABORT_EN
        bus.abort = 1'b0;
`endif
        repeat (3) @(negedge clk);
        rst    = 1'b0;
        mon_en = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_pulse", int'(bus.pulse), 0);
        check("idle_busy", int'(bus.busy), 0);
        check("idle_done", int'(bus.done), 0);
        check("idle_left", int'(bus.pulses_left), 0);

        run_burst(3, 4, 1'b0);
        run_burst(0, 3, 1'b0);
        run_burst(5, 0, 1'b0);
        run_burst(2, 3, 1'b1);
        reset_mid_burst();
        run_burst(4, 2, 1'b0);
        run_burst(15, 2, 1'b0);
`ifdef PULSE_CTRL_ABORT_EN
        abort_burst();
        run_burst(1, 2, 1'b0);
`endif
        for (int i = 0; i < 12; i++) begin
            run_burst(int'($urandom_range(15, 0)), int'($urandom_range(5, 0)),
                      1'($urandom_range(1, 0)));
            repeat (int'($urandom_range(3, 0))) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
